inst_mem_pipe: RTL and testbench

Parametrised, synchronous instruction memory for the fetch stage. Replaces the combinational ROM lookup with a request/response handshake, a configurable read latency (wait states), alignment/range error reporting, a flush input for branch redirects, and a write port for program loading from the testbench or a debug loader. Sits between the PC/IF stage and the IF/ID pipeline register.

---
 rtl/inst_mem_pipe.sv | 149 ++++++++++++++
 tb/tb_inst_mem_pipe.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_pipe.sv
// -----------------------------------------------------------------------------
// inst_mem_pipe
//   Synchronous instruction memory for the fetch stage. A request/response
//   handshake with a configurable number of wait states, alignment and range
//   error reporting, a flush/disable abort path and a program-load write port.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low (array contents are kept)
//   ce         memory enable; 0 aborts any in-flight request
//   req_valid  fetch request present
//   req_ready  request can be accepted this cycle
//   req_addr   byte address of the instruction
//   resp_valid response present, held until resp_ready
//   resp_ready fetch stage accepts the response
//   resp_data  instruction word, 0 when no response or on error
//   resp_err   request was misaligned or out of range
//   flush      synchronous abort of the in-flight request
//   busy       a request has been accepted and not yet responded
//   load_we    program-load write enable
//   load_addr  byte address of the load write
//   load_data  word to write
// -----------------------------------------------------------------------------
module inst_mem_pipe #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       DEPTH_LOG2 = 10,
   parameter int unsigned       LATENCY    = 1,
   parameter logic [DATA_W-1:0] INIT_WORD  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err,
   input  logic              flush,
   output logic              busy,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data
);

   localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic                  r_err;
   logic                  r_resp_valid;
   logic [DATA_W-1:0]     r_resp_data;
   logic                  r_resp_err;

   logic [DATA_W-1:0]     r_mem [0:DEPTH-1] = '{default: INIT_WORD};

   logic                  w_req_ready;
   logic                  w_accept;
   logic                  w_req_err;
   logic                  w_load_ok;
   logic [DEPTH_LOG2-1:0] w_req_idx;
   logic [DEPTH_LOG2-1:0] w_load_idx;

   // Any address bit above the word-index field means out of range.
   assign w_req_idx  = req_addr[DEPTH_LOG2+1:2];
   assign w_req_err  = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != '0);
   assign w_load_idx = load_addr[DEPTH_LOG2+1:2];
   assign w_load_ok  = (load_addr[1:0] == 2'b00) && ((load_addr >> (DEPTH_LOG2 + 2)) == '0);

   assign w_req_ready = ce && !flush && ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));
   assign w_accept    = req_valid && w_req_ready;

   assign req_ready  = w_req_ready;
   assign busy       = (r_state != S_IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_err   = r_resp_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_err        <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_err   <= 1'b0;
      end else if (!ce || flush) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_RESP: begin
               if (w_accept) begin
                  r_idx <= w_req_idx;
                  r_err <= w_req_err;
                  if (LATENCY == 1) begin
                     // No wait states: the accept edge is also the edge entering RESP,
                     // so the array is read with the live request address.
                     r_state      <= S_RESP;
                     r_resp_valid <= 1'b1;
                     r_resp_data  <= w_req_err ? '0 : r_mem[w_req_idx];
                     r_resp_err   <= w_req_err;
                  end else begin
                     r_state      <= S_WAIT;
                     r_cnt        <= LAT_M1;
                     r_resp_valid <= 1'b0;
                     r_resp_data  <= '0;
                     r_resp_err   <= 1'b0;
                  end
               end else if ((r_state == S_RESP) && resp_ready) begin
                  r_state      <= S_IDLE;
                  r_resp_valid <= 1'b0;
                  r_resp_data  <= '0;
                  r_resp_err   <= 1'b0;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd1) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_data  <= r_err ? '0 : r_mem[r_idx];
                  r_resp_err   <= r_err;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Load writes use non-blocking semantics, so a read on the same edge returns old data.
   always_ff @(posedge clk) begin
      if (load_we && w_load_ok) begin
         r_mem[w_load_idx] <= load_data;
      end
   end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_pipe
//   Three instances of inst_mem_pipe (LATENCY 1, 3, 4) sharing clock, reset and
//   load port. Accepted requests push an expected response computed from a
//   reference copy of the loaded program; delivered responses are popped and
//   compared. Scenario tasks add inline timing and stability checks.
// -----------------------------------------------------------------------------
module tb_inst_mem_pipe;

   typedef struct {
      int          dut;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_we = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_data = '0;

   logic        ce         [3];
   logic        req_valid  [3];
   logic        resp_ready [3];
   logic        flush      [3];
   logic [31:0] req_addr   [3];
   logic        req_ready  [3];
   logic        resp_valid [3];
   logic        resp_err   [3];
   logic        busy       [3];
   logic [31:0] resp_data  [3];

   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q [$];
   exp_t        e_mon;
   logic [31:0] ref_mem [0:1023];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      inst_mem_pipe #(
         .ADDR_W     (32),
         .DATA_W     (32),
         .DEPTH_LOG2 (10),
         .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
         .INIT_WORD  (32'h00000000)
      ) u_dut (
         .clk        (clk),
         .rst        (rst_n),
         .ce         (ce[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_addr   (req_addr[g]),
         .resp_valid (resp_valid[g]),
         .resp_ready (resp_ready[g]),
         .resp_data  (resp_data[g]),
         .resp_err   (resp_err[g]),
         .flush      (flush[g]),
         .busy       (busy[g]),
         .load_we    (load_we),
         .load_addr  (load_addr),
         .load_data  (load_data)
      );
   end

   function automatic exp_t model(input int d, input logic [31:0] a);
      exp_t e;
      e.dut = d;
      if ((a[1:0] != 2'b00) || (a >= 32'h0000_1000)) begin
         e.err  = 1'b1;
         e.data = '0;
      end else begin
         e.err  = 1'b0;
         e.data = ref_mem[a[11:2]];
      end
      return e;
   endfunction

   // Scoreboard: pop delivered responses first, then push newly accepted requests.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (resp_valid[d] && resp_ready[d] && ce[d] && !flush[d]) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL resp_unexpected: dut %0d got err=%b data=%h, expected no response",
                           d, resp_err[d], resp_data[d]);
               end else begin
                  e_mon = exp_q.pop_front();
                  if (e_mon.dut != d || resp_err[d] !== e_mon.err || resp_data[d] !== e_mon.data) begin
                     errors++;
                     $display("FAIL resp_sb: dut %0d got err=%b data=%h, expected dut %0d err=%b data=%h",
                              d, resp_err[d], resp_data[d], e_mon.dut, e_mon.err, e_mon.data);
                  end
               end
            end
            if (req_valid[d] && req_ready[d]) begin
               exp_q.push_back(model(d, req_addr[d]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [31:0] a, input logic [31:0] v);
      load_we   = 1'b1;
      load_addr = a;
      load_data = v;
      tick();
      load_we   = 1'b0;
      if ((a[1:0] == 2'b00) && (a < 32'h0000_1000)) ref_mem[a[11:2]] = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({resp_valid[d], resp_err[d], busy[d]} !== 3'b000 || resp_data[d] !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: dut %0d got valid=%b err=%b busy=%b data=%h, expected all 0",
                     d, resp_valid[d], resp_err[d], busy[d], resp_data[d]);
         end
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: dut %0d got req_ready=%b, expected 1", d, req_ready[d]);
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      load_word(32'h0, 32'h34011100);
      load_word(32'h4, 32'h30020020);
      load_word(32'h8, 32'hA5A55A5A);
      resp_ready[0] = 1'b1;
      req_valid[0]  = 1'b1;
      req_addr[0]   = 32'h0;
      tick();
      req_addr[0] = 32'h4;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'h34011100 || resp_err[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: got valid=%b data=%h err=%b, expected 1 34011100 0",
                  resp_valid[0], resp_data[0], resp_err[0]);
      end
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'h30020020 || resp_err[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second: got valid=%b data=%h err=%b, expected 1 30020020 0",
                  resp_valid[0], resp_data[0], resp_err[0]);
      end
      tick();
      @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b valid=%b, expected 0 0", busy[0], resp_valid[0]);
      end
      tick();
   endtask

   task automatic test_latency();
      resp_ready[1] = 1'b1;
      req_valid[1]  = 1'b1;
      req_addr[1]   = 32'h8;
      @(negedge clk);
      checks++;
      if (req_ready[1] !== 1'b1) begin
         errors++;
         $display("FAIL lat3_accept: got req_ready=%b, expected 1", req_ready[1]);
      end
      tick();
      req_valid[1] = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         checks++;
         if ({busy[1], req_ready[1], resp_valid[1]} !== 3'b100) begin
            errors++;
            $display("FAIL lat3_wait: cycle N+%0d got busy=%b ready=%b valid=%b, expected 1 0 0",
                     c, busy[1], req_ready[1], resp_valid[1]);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (resp_valid[1] !== 1'b1 || resp_data[1] !== 32'hA5A55A5A) begin
         errors++;
         $display("FAIL lat3_resp: got valid=%b data=%h, expected 1 a5a55a5a", resp_valid[1], resp_data[1]);
      end
      tick();
      @(negedge clk);
      checks++;
      if (busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL lat3_idle: got busy=%b, expected 0", busy[1]);
      end
      tick();
   endtask

   task automatic test_errors();
      resp_ready[0] = 1'b1;
      req_valid[0]  = 1'b1;
      req_addr[0]   = 32'h6;
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({resp_valid[0], resp_err[0]} !== 2'b11 || resp_data[0] !== 32'h0) begin
         errors++;
         $display("FAIL err_misalign: got valid=%b err=%b data=%h, expected 1 1 00000000",
                  resp_valid[0], resp_err[0], resp_data[0]);
      end
      tick();
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h1000;
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_err[0] !== 1'b1 || resp_data[0] !== 32'h0) begin
         errors++;
         $display("FAIL err_range: got err=%b data=%h, expected 1 00000000", resp_err[0], resp_data[0]);
      end
      tick();
      load_word(32'h0000_1000, 32'hDEADBEEF);
      load_word(32'h8000_0000, 32'h11111111);
      load_word(32'h0000_0002, 32'hCAFEF00D);
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h0;
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_data[0] !== 32'h34011100 || resp_err[0] !== 1'b0) begin
         errors++;
         $display("FAIL err_load_ignored: got data=%h err=%b, expected 34011100 0", resp_data[0], resp_err[0]);
      end
      tick();
   endtask

   task automatic test_stall();
      resp_ready[0] = 1'b0;
      req_valid[0]  = 1'b1;
      req_addr[0]   = 32'h4;
      tick();
      req_valid[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'h30020020 || resp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got valid=%b data=%h err=%b, expected 1 30020020 0",
                     c, resp_valid[0], resp_data[0], resp_err[0]);
         end
         tick();
      end
      resp_ready[0] = 1'b1;
      req_valid[0]  = 1'b1;
      req_addr[0]   = 32'h0;
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL stall_release_ready: got req_ready=%b, expected 1", req_ready[0]);
      end
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'h34011100) begin
         errors++;
         $display("FAIL stall_next: got valid=%b data=%h, expected 1 34011100", resp_valid[0], resp_data[0]);
      end
      tick();
   endtask

   task automatic test_flush();
      resp_ready[2] = 1'b1;
      req_valid[2]  = 1'b1;
      req_addr[2]   = 32'h8;
      tick();
      req_valid[2] = 1'b0;
      tick();
      flush[2] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b0 || busy[2] !== 1'b1) begin
         errors++;
         $display("FAIL flush_wait: got ready=%b busy=%b, expected 0 1", req_ready[2], busy[2]);
      end
      tick();
      flush[2] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({busy[2], resp_valid[2]} !== 2'b00 || resp_data[2] !== 32'h0) begin
            errors++;
            $display("FAIL flush_abort: cycle %0d got busy=%b valid=%b data=%h, expected 0 0 00000000",
                     c, busy[2], resp_valid[2], resp_data[2]);
         end
         tick();
      end
      checks++;
      if (exp_q.size() != 1) begin
         errors++;
         $display("FAIL flush_pending: got %0d outstanding, expected 1 aborted", exp_q.size());
      end
      exp_q.delete();

      flush[2]     = 1'b1;
      req_valid[2] = 1'b1;
      req_addr[2]  = 32'h0;
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_ready: got req_ready=%b, expected 0", req_ready[2]);
      end
      tick();
      flush[2]     = 1'b0;
      req_valid[2] = 1'b0;
      @(negedge clk);
      checks++;
      if (busy[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_busy: got busy=%b, expected 0", busy[2]);
      end
      tick();

      req_valid[2] = 1'b1;
      req_addr[2]  = 32'h8;
      tick();
      req_valid[2] = 1'b0;
      repeat (4) tick();
      @(negedge clk);
      checks++;
      if (busy[2] !== 1'b0) begin
         errors++;
         $display("FAIL flush_recover: got busy=%b, expected 0", busy[2]);
      end
      tick();
   endtask

   task automatic test_ce_abort();
      resp_ready[0] = 1'b0;
      req_valid[0]  = 1'b1;
      req_addr[0]   = 32'h4;
      tick();
      req_valid[0] = 1'b0;
      ce[0]        = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL ce_off_ready: got ready=%b valid=%b, expected 0 1", req_ready[0], resp_valid[0]);
      end
      tick();
      ce[0] = 1'b1;
      @(negedge clk);
      checks++;
      if ({resp_valid[0], busy[0], resp_err[0]} !== 3'b000 || resp_data[0] !== 32'h0) begin
         errors++;
         $display("FAIL ce_abort: got valid=%b busy=%b err=%b data=%h, expected 0 0 0 00000000",
                  resp_valid[0], busy[0], resp_err[0], resp_data[0]);
      end
      tick();
      checks++;
      if (exp_q.size() != 1) begin
         errors++;
         $display("FAIL ce_pending: got %0d outstanding, expected 1 aborted", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_async_reset();
      resp_ready[0] = 1'b0;
      req_valid[0]  = 1'b1;
      req_addr[0]   = 32'h0;
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (resp_valid[0] !== 1'b0 || busy[0] !== 1'b0 || resp_data[0] !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b busy=%b data=%h before edge, expected 0 0 00000000",
                  resp_valid[0], busy[0], resp_data[0]);
      end
      exp_q.delete();
      tick();
      rst_n         = 1'b1;
      resp_ready[0] = 1'b1;
      req_valid[0]  = 1'b1;
      req_addr[0]   = 32'h0;
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_data[0] !== 32'h34011100) begin
         errors++;
         $display("FAIL reset_keeps_mem: got valid=%b data=%h, expected 1 34011100", resp_valid[0], resp_data[0]);
      end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      for (int d = 0; d < 3; d++) begin
         ce[d]         = 1'b1;
         req_valid[d]  = 1'b0;
         resp_ready[d] = 1'b0;
         flush[d]      = 1'b0;
         req_addr[d]   = '0;
      end
      test_reset();
      test_back_to_back();
      test_latency();
      test_errors();
      test_stall();
      test_flush();
      test_ce_abort();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
